// File: rtl/scrc_byte_serializer.sv
// -----------------------------------------------------------------------------
// scrc_byte_serializer
//
// Purpose:
//   Accepts framed bytes and feeds them one bit at a time to an external serial
//   CRC stage. Each bit is presented on ser_data for GAP_CYCLES idle cycles and
//   then qualified by a one-cycle ser_enable strobe. The first byte of a frame
//   (s_sof) is preceded by a one-cycle ser_init pulse that clears the CRC stage.
//   After the last bit of the frame (s_eof) the running CRC returned on crc_in
//   is captured into crc_result and flagged with a one-cycle crc_valid pulse.
//
// Configuration:
//   SCRC_MSB_FIRST_EN  defined   -> bits are sent s_data[7] first
//                      undefined -> bits are sent s_data[0] first (default)
//   GAP_CYCLES         idle cycles before each strobe, legal range 1..15
//
// Ports:
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous active-high reset
//   s_data      in   8   byte offered for serialization
//   s_valid     in   1   s_data / s_sof / s_eof are valid
//   s_sof       in   1   first byte of a frame
//   s_eof       in   1   last byte of a frame
//   s_ready     out  1   byte accepted on this edge when s_valid is high
//   ser_data    out  1   current serial bit
//   ser_enable  out  1   one-cycle strobe qualifying ser_data
//   ser_init    out  1   one-cycle CRC clear at frame start
//   crc_in      in   16  running CRC from the CRC stage
//   crc_result  out  16  CRC captured at frame end
//   crc_valid   out  1   one-cycle pulse when crc_result is updated
// -----------------------------------------------------------------------------
module scrc_byte_serializer #(
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_sof,
  input  logic        s_eof,
  output logic        s_ready,
  output logic        ser_data,
  output logic        ser_enable,
  output logic        ser_init,
  input  logic [15:0] crc_in,
  output logic [15:0] crc_result,
  output logic        crc_valid
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INIT, GAP, SHIFT, DONE} state_t;

  state_t      state_reg,      state_next;
  logic [7:0]  byte_reg,       byte_next;
  logic        eof_reg,        eof_next;
  logic [2:0]  bit_cnt_reg,    bit_cnt_next;
  logic [3:0]  gap_cnt_reg,    gap_cnt_next;
  logic [15:0] crc_result_reg, crc_result_next;
  logic        crc_valid_reg,  crc_valid_next;

  // The byte is stored already in transmission order, so bit_cnt_reg always
  // indexes the pending bit directly regardless of the bit-order option.
  logic [7:0] ordered_data;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_order
`ifdef SCRC_MSB_FIRST_EN
      assign ordered_data[gi] = s_data[7 - gi];
`else
      assign ordered_data[gi] = s_data[gi];
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      byte_reg       <= '0;
      eof_reg        <= 1'b0;
      bit_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
      crc_result_reg <= '0;
      crc_valid_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      byte_reg       <= byte_next;
      eof_reg        <= eof_next;
      bit_cnt_reg    <= bit_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
      crc_result_reg <= crc_result_next;
      crc_valid_reg  <= crc_valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    byte_next       = byte_reg;
    eof_next        = eof_reg;
    bit_cnt_next    = bit_cnt_reg;
    gap_cnt_next    = '0;           // restarts on every GAP entry
    crc_result_next = crc_result_reg;
    crc_valid_next  = 1'b0;
    s_ready         = 1'b0;
    ser_data        = 1'b0;
    ser_enable      = 1'b0;
    ser_init        = 1'b0;

    case (state_reg)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          byte_next    = ordered_data;
          eof_next     = s_eof;
          bit_cnt_next = '0;
          state_next   = s_sof ? INIT : GAP;
        end
      end
      INIT: begin
        ser_init   = 1'b1;
        state_next = GAP;
      end
      GAP: begin
        // Bit is driven ahead of its strobe so the CRC stage sees a settled value.
        ser_data = byte_reg[bit_cnt_reg];
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = SHIFT;
        end else begin
          gap_cnt_next = gap_cnt_reg + 4'd1;
        end
      end
      SHIFT: begin
        ser_data   = byte_reg[bit_cnt_reg];
        ser_enable = 1'b1;
        if (bit_cnt_reg == 3'd7) begin
          state_next = eof_reg ? DONE : IDLE;
        end else begin
          bit_cnt_next = bit_cnt_reg + 3'd1;
          state_next   = GAP;
        end
      end
      DONE: begin
        // The CRC stage has absorbed the last strobe by now; capture its value.
        crc_result_next = crc_in;
        crc_valid_next  = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign crc_result = crc_result_reg;
  assign crc_valid  = crc_valid_reg;

endmodule

// File: doc/scrc_byte_serializer.md
SCRC_BYTE_SERIALIZER -- requirements
Module: scrc_byte_serializer

Interface
REQ-001 Parameter GAP_CYCLES, default 1, SHALL set the idle cycles (ser_enable low) before each bit strobe; legal range 1..15.
REQ-002 clk  input  1  SHALL be the single rising-edge clock for all state.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 s_data  input  8  SHALL carry the byte offered for serialization.
REQ-005 s_valid  input  1  SHALL indicate that s_data, s_sof and s_eof are valid.
REQ-006 s_sof  input  1  SHALL mark the first byte of a frame.
REQ-007 s_eof  input  1  SHALL mark the last byte of a frame.
REQ-008 s_ready  output  1  SHALL indicate that a byte is accepted on this edge when s_valid is high.
REQ-009 ser_data  output  1  SHALL carry the current serial bit to the CRC stage.
REQ-010 ser_enable  output  1  SHALL be a one-cycle strobe qualifying ser_data.
REQ-011 ser_init  output  1  SHALL be a one-cycle pulse clearing the CRC stage at frame start.
REQ-012 crc_in  input  16  SHALL carry the running CRC returned by the CRC stage.
REQ-013 crc_result  output  16  SHALL hold the CRC captured at frame end.
REQ-014 crc_valid  output  1  SHALL pulse for one cycle when crc_result is updated.

Function
REQ-015 The FSM SHALL have the states IDLE, INIT, GAP, SHIFT and DONE; s_ready SHALL be high only in IDLE.
REQ-016 IDLE: on s_valid&&s_ready, the block SHALL latch s_data and s_eof, clear the bit counter, and go to INIT if s_sof else GAP.
REQ-017 INIT SHALL last exactly one cycle with ser_init=1, then go to GAP.
REQ-018 GAP SHALL last GAP_CYCLES cycles with ser_enable=0 and ser_data already driving the pending bit, then go to SHIFT.
REQ-019 SHIFT SHALL last one cycle with ser_enable=1; ser_data SHALL be stable across the GAP+SHIFT window of each bit.
REQ-020 After SHIFT of bit 7 the block SHALL go to DONE if the latched eof is set, else to IDLE; otherwise it SHALL increment the counter and go to GAP.
REQ-021 DONE SHALL last one cycle; on its exit edge, crc_result<=crc_in and crc_valid<=1 for exactly one cycle; next state IDLE.
REQ-022 ser_data SHALL be 0 in IDLE, INIT and DONE.
REQ-023 A byte with s_sof=s_eof=1 SHALL form a complete single-byte frame.
REQ-024 s_sof on a non-first byte SHALL restart the CRC via INIT; any partial CRC is discarded without a crc_valid pulse.
REQ-025 In IDLE the block SHALL wait indefinitely between bytes of an open frame; ser_enable SHALL stay low.
REQ-026 Per-byte latency from the accept edge SHALL be [1 if sof] + 8*(GAP_CYCLES+1) cycles to IDLE, plus 1 DONE cycle on eof.

Reset
REQ-027 While reset is high: state=IDLE, s_ready=1, ser_data=0, ser_enable=0, ser_init=0, crc_result=16'h0000, crc_valid=0, counter=0.
REQ-028 Reset mid-frame SHALL discard the frame immediately, with no ser_enable, ser_init or crc_valid pulse generated after reset is asserted.

Configuration
REQ-029 With SCRC_MSB_FIRST_EN defined, bits SHALL be sent s_data[7] first; when undefined, s_data[0] first (LSB-first, the default).

Verification
REQ-030 Reset asserted during bit 3 of a frame -> all outputs at REQ-027 values within the same cycle; no crc_valid afterwards.
REQ-031 GAP_CYCLES=1, single byte 8'h80 sof+eof accepted at edge 0 -> ser_init high in cycle 1; ser_enable high in cycles 3,5,...,17; ser_data on strobes 0,0,0,0,0,0,0,1; crc_valid high in cycle 19 with crc_result=crc_in sampled in cycle 18; s_ready high in cycle 19.
REQ-032 Three-byte frame 8'h01,8'h02,8'h03 (sof on first, eof on last), s_valid held high -> exactly one ser_init pulse, 24 ser_enable strobes, exactly one crc_valid.
REQ-033 GAP_CYCLES=3, byte 8'hA5 sof+eof -> strobes 4 cycles apart; bit sequence 1,0,1,0,0,1,0,1; crc_valid 1+32+1+1=35 cycles after accept.
REQ-034 SCRC_MSB_FIRST_EN defined, byte 8'h80 sof+eof -> first strobed bit 1, remaining seven bits 0.
REQ-035 Byte 8'h11 with sof, no eof, then s_valid low for 50 cycles -> block in IDLE with s_ready=1, ser_enable=0, no crc_valid; a later 8'h22 with eof completes the frame with one crc_valid.
